// File: rtl/axi2apb_bridge_mp.sv
// ---------------------------------------------------------------------------
// axi2apb_bridge_mp
// AXI4-Lite slave to APB master bridge serving NUM_SLV APB slaves, each with
// its own PSEL line. The slave is decoded from the AXI address; unmapped
// addresses get DECERR without touching APB. Reads and writes are arbitrated
// round robin (read first after reset), only one transaction is outstanding,
// and an ACCESS phase that waits TOUT_CYCLES without PREADY is abandoned
// with SLVERR.
//
// Optional feature macro: AXI2APB_APB4_EN adds WSTRB, PSTRB and PPROT.
//
// Ports
//   ACLK, ARESET                 clock, synchronous active-high reset
//   AW*/W*/B*                    AXI4-Lite write address, data and response
//   AR*/R*                       AXI4-Lite read address and data
//   PADDR/PWRITE/PENABLE/PWDATA  APB master request, shared by all slaves
//   PSEL[NUM_SLV]                one-hot slave select
//   PRDATA/PREADY/PSLVERR        per-slave APB returns, packed by slave index
//   WSTRB/PSTRB/PPROT            APB4 extras (AXI2APB_APB4_EN only)
// ---------------------------------------------------------------------------
module axi2apb_bridge_mp #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int APB_ADDR_WIDTH = 16,
  parameter int NUM_SLV        = 4,
  parameter int TOUT_CYCLES    = 16,
  parameter int UD             = 1
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [ADDR_WIDTH-1:0]         AWADDR,
  input  logic                          AWVALID,
  input  logic [2:0]                    AWPROT,
  output logic                          AWREADY,
  input  logic [DATA_WIDTH-1:0]         WDATA,
  input  logic                          WVALID,
  output logic                          WREADY,
  output logic [1:0]                    BRESP,
  output logic                          BVALID,
  input  logic                          BREADY,
  input  logic [ADDR_WIDTH-1:0]         ARADDR,
  input  logic                          ARVALID,
  input  logic [2:0]                    ARPROT,
  output logic                          ARREADY,
  output logic [DATA_WIDTH-1:0]         RDATA,
  output logic [1:0]                    RRESP,
  output logic                          RVALID,
  input  logic                          RREADY,
`ifdef AXI2APB_APB4_EN
  input  logic [DATA_WIDTH/8-1:0]       WSTRB,
  output logic [DATA_WIDTH/8-1:0]       PSTRB,
  output logic [2:0]                    PPROT,
`endif
  output logic [APB_ADDR_WIDTH-1:0]     PADDR,
  output logic                          PWRITE,
  output logic                          PENABLE,
  output logic [NUM_SLV-1:0]            PSEL,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic [NUM_SLV*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]            PREADY,
  input  logic [NUM_SLV-1:0]            PSLVERR
);

  localparam int SLV_BITS = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [SLV_BITS:0] NUM_SLV_L = (SLV_BITS + 1)'(NUM_SLV);
  localparam logic [7:0] TOUT_L = 8'(TOUT_CYCLES);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                      state_r;
  state_t                      state_nxt_s;

  logic                        prio_wr_r;   // 1: write wins the next tie
  logic                        is_wr_r;
  logic [SLV_BITS-1:0]         idx_r;
  logic [7:0]                  cnt_r;
  logic [APB_ADDR_WIDTH-1:0]   paddr_r;
  logic                        pwrite_r;
  logic                        penable_r;
  logic [NUM_SLV-1:0]          psel_r;
  logic [DATA_WIDTH-1:0]       pwdata_r;
  logic                        bvalid_r;
  logic [1:0]                  bresp_r;
  logic                        rvalid_r;
  logic [1:0]                  rresp_r;
  logic [DATA_WIDTH-1:0]       rdata_r;

  logic                        idle_s;
  logic                        grant_wr_s;
  logic                        grant_rd_s;
  logic [ADDR_WIDTH-1:0]       acc_addr_s;
  logic [SLV_BITS-1:0]         acc_idx_s;
  logic                        acc_mapped_s;
  logic                        sel_ready_s;
  logic                        sel_err_s;
  logic [DATA_WIDTH-1:0]       sel_rdata_s;
  logic                        tout_hit_s;
  logic                        resp_done_s;

  // Arbitration, address decode and selected-slave return muxing
  always_comb begin
    idle_s     = (state_r == ST_IDLE) && !ARESET;
    grant_wr_s = 1'b0;
    grant_rd_s = 1'b0;
    // A lone AW or W never blocks a pending read
    if (idle_s && AWVALID && WVALID && (!ARVALID || prio_wr_r)) begin
      grant_wr_s = 1'b1;
    end else if (idle_s && ARVALID) begin
      grant_rd_s = 1'b1;
    end else begin
      grant_wr_s = 1'b0;
      grant_rd_s = 1'b0;
    end
    acc_addr_s   = grant_wr_s ? AWADDR : ARADDR;
    acc_idx_s    = acc_addr_s[APB_ADDR_WIDTH +: SLV_BITS];
    // Mapped only if the index is populated and nothing above it is set
    acc_mapped_s = ({1'b0, acc_idx_s} < NUM_SLV_L) &&
                   ((acc_addr_s >> (APB_ADDR_WIDTH + SLV_BITS)) == '0);
    sel_ready_s  = PREADY[idx_r];
    sel_err_s    = PSLVERR[idx_r];
    sel_rdata_s  = PRDATA[32'(idx_r) * DATA_WIDTH +: DATA_WIDTH];
    tout_hit_s   = (cnt_r == TOUT_L);
    resp_done_s  = is_wr_r ? (bvalid_r && BREADY) : (rvalid_r && RREADY);
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_wr_s || grant_rd_s) begin
          state_nxt_s = acc_mapped_s ? ST_SETUP : ST_RESP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: state_nxt_s = ST_ACCESS;
      ST_ACCESS: begin
        if (sel_ready_s || tout_hit_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_RESP: begin
        if (resp_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

`ifdef AXI2APB_APB4_EN
  logic [DATA_WIDTH/8-1:0] pstrb_r;
  logic [2:0]              pprot_r;

  // APB4 strobe and protection, latched at acceptance and held through ACCESS
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      pstrb_r <= '0;
      pprot_r <= 3'b000;
    end else if (grant_wr_s || grant_rd_s) begin
      if (acc_mapped_s) begin
        pstrb_r <= grant_wr_s ? WSTRB : '0;
        pprot_r <= grant_wr_s ? AWPROT : ARPROT;
      end
    end
  end

  assign PSTRB = pstrb_r;
  assign PPROT = pprot_r;

  logic unused_ok_s;
  assign unused_ok_s = (UD != 0);
`else
  logic unused_ok_s;
  assign unused_ok_s = ^{(UD != 0), AWPROT, ARPROT};
`endif

  // APB request, timeout counter and AXI response registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      prio_wr_r <= 1'b0;
      is_wr_r   <= 1'b0;
      idx_r     <= '0;
      cnt_r     <= 8'd0;
      paddr_r   <= '0;
      pwrite_r  <= 1'b0;
      penable_r <= 1'b0;
      psel_r    <= '0;
      pwdata_r  <= '0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
      rvalid_r  <= 1'b0;
      rresp_r   <= RESP_OKAY;
      rdata_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_wr_s || grant_rd_s) begin
            prio_wr_r <= grant_rd_s;
            is_wr_r   <= grant_wr_s;
            if (acc_mapped_s) begin
              idx_r             <= acc_idx_s;
              paddr_r           <= acc_addr_s[APB_ADDR_WIDTH-1:0];
              pwrite_r          <= grant_wr_s;
              pwdata_r          <= grant_wr_s ? WDATA : '0;
              psel_r            <= '0;
              psel_r[acc_idx_s] <= 1'b1;
            end else begin
              // Unmapped: answer straight away without any APB cycle
              bvalid_r <= grant_wr_s;
              rvalid_r <= grant_rd_s;
              bresp_r  <= grant_wr_s ? RESP_DECERR : RESP_OKAY;
              rresp_r  <= grant_rd_s ? RESP_DECERR : RESP_OKAY;
              rdata_r  <= '0;
            end
          end
        end
        ST_SETUP: begin
          penable_r <= 1'b1;
          cnt_r     <= 8'd0;
        end
        ST_ACCESS: begin
          if (sel_ready_s || tout_hit_s) begin
            psel_r    <= '0;
            penable_r <= 1'b0;
            // PREADY on the last allowed cycle still counts as a completion
            if (is_wr_r) begin
              bvalid_r <= 1'b1;
              bresp_r  <= (sel_ready_s && !sel_err_s) ? RESP_OKAY : RESP_SLVERR;
            end else begin
              rvalid_r <= 1'b1;
              rresp_r  <= (sel_ready_s && !sel_err_s) ? RESP_OKAY : RESP_SLVERR;
              rdata_r  <= (sel_ready_s && !sel_err_s) ? sel_rdata_s : '0;
            end
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_RESP: begin
          if (resp_done_s) begin
            bvalid_r <= 1'b0;
            rvalid_r <= 1'b0;
            bresp_r  <= RESP_OKAY;
            rresp_r  <= RESP_OKAY;
            rdata_r  <= '0;
          end
        end
        default: begin
          psel_r    <= '0;
          penable_r <= 1'b0;
        end
      endcase
    end
  end

  assign AWREADY = grant_wr_s;
  assign WREADY  = grant_wr_s;
  assign ARREADY = grant_rd_s;
  assign BVALID  = bvalid_r;
  assign BRESP   = bresp_r;
  assign RVALID  = rvalid_r;
  assign RRESP   = rresp_r;
  assign RDATA   = rdata_r;
  assign PADDR   = paddr_r;
  assign PWRITE  = pwrite_r;
  assign PENABLE = penable_r;
  assign PSEL    = psel_r;
  assign PWDATA  = pwdata_r;

endmodule

// File: tb/tb_axi2apb_bridge_mp.sv
// ---------------------------------------------------------------------------
// tb_axi2apb_bridge_mp
// Transaction-level bench for axi2apb_bridge_mp with default parameters.
// Each transaction's expected grant, response cycle, response code and read
// data are derived from the address map and the slave behaviour chosen for
// that transaction. Under AXI2APB_APB4_EN the strobe/protection outputs are
// checked as well.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi2apb_bridge_mp;
  localparam int DW   = 32;
  localparam int NS   = 4;
  localparam int TOUT = 16;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic [31:0]     AWADDR, ARADDR, WDATA, RDATA, PWDATA;
  logic            AWVALID, WVALID, ARVALID, BREADY, RREADY;
  logic            AWREADY, WREADY, ARREADY, BVALID, RVALID;
  logic [2:0]      AWPROT, ARPROT;
  logic [1:0]      BRESP, RRESP;
  logic [15:0]     PADDR;
  logic            PWRITE, PENABLE;
  logic [NS-1:0]   PSEL, PREADY, PSLVERR;
  logic [NS*DW-1:0] PRDATA;
`ifdef AXI2APB_APB4_EN
  logic [3:0]      WSTRB, PSTRB;
  logic [2:0]      PPROT;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit wr_turn;   // reference: a write wins the next read/write tie

  always #5 ACLK = ~ACLK;

  axi2apb_bridge_mp #(
    .ADDR_WIDTH(32), .DATA_WIDTH(DW), .APB_ADDR_WIDTH(16),
    .NUM_SLV(NS), .TOUT_CYCLES(TOUT), .UD(1)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWPROT(AWPROT), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARPROT(ARPROT), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
`ifdef AXI2APB_APB4_EN
    .WSTRB(WSTRB), .PSTRB(PSTRB), .PPROT(PPROT),
`endif
    .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE), .PSEL(PSEL),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_axi"}, {AWREADY, WREADY, ARREADY, BVALID, BRESP, RVALID, RRESP, RDATA}, 64'd0);
    check_eq({tag, "_apb"}, {PSEL, PENABLE, PWRITE, PADDR}, 64'd0);
    check_eq({tag, "_pwdata"}, PWDATA, 64'd0);
`ifdef AXI2APB_APB4_EN
    check_eq({tag, "_apb4"}, {PSTRB, PPROT}, 64'd0);
`endif
  endtask

  // One AXI transaction. wait_n > TOUT models a slave that never answers.
  task automatic run_txn(input bit req_wr, input bit req_rd,
                         input logic [31:0] waddr, input logic [31:0] raddr,
                         input logic [31:0] wdata, input int wait_n, input bit slv_err,
                         input logic [31:0] rdv, input int resp_dly,
                         input logic [3:0] wstrb, input logic [2:0] awprot,
                         input logic [2:0] arprot);
    bit          srv_wr, mapped, psel_ok, pen_ok, apb_ok, hold_ok;
    logic [31:0] a, rdata_exp;
    logic [1:0]  resp_exp;
    int          idx, v_exp, v_seen;
    srv_wr  = req_wr && (!req_rd || wr_turn);
    wr_turn = !srv_wr;
    a       = srv_wr ? waddr : raddr;
    mapped  = (a < 32'(NS) * 32'h0001_0000);
    idx     = int'(a / 32'h0001_0000);
    if (!mapped) begin
      v_exp = 1; resp_exp = 2'b11; rdata_exp = 32'd0;
    end else if (wait_n <= TOUT) begin
      v_exp = 3 + wait_n; resp_exp = slv_err ? 2'b10 : 2'b00;
      rdata_exp = (srv_wr || slv_err) ? 32'd0 : rdv;
    end else begin
      v_exp = TOUT + 3; resp_exp = 2'b10; rdata_exp = 32'd0;
    end

    @(posedge ACLK); #1;
    AWVALID = req_wr; WVALID = req_wr; AWADDR = waddr; WDATA = wdata; AWPROT = awprot;
    ARVALID = req_rd; ARADDR = raddr; ARPROT = arprot;
    BREADY = (resp_dly == 0); RREADY = (resp_dly == 0);
`ifdef AXI2APB_APB4_EN
    WSTRB = wstrb;
`endif
    // Non-selected slaves look ready and inverted-error so wrong muxing shows
    PREADY  = '1;
    PSLVERR = slv_err ? '0 : '1;
    for (int s = 0; s < NS; s++) PRDATA[s*DW +: DW] = $urandom;
    if (mapped) begin
      PREADY[idx]          = 1'b0;
      PSLVERR[idx]         = slv_err;
      PRDATA[idx*DW +: DW] = rdv;
    end
    @(negedge ACLK);
    check_eq("grant", {AWREADY, WREADY, ARREADY}, {srv_wr, srv_wr, !srv_wr});

    v_seen = -1; psel_ok = 1'b1; pen_ok = 1'b1; apb_ok = 1'b1; hold_ok = 1'b1;
    for (int c = 1; c <= TOUT + 10 && v_seen < 0; c++) begin
      @(posedge ACLK); #1;
      AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
      if (mapped) PREADY[idx] = (c >= 2 + wait_n);
      @(negedge ACLK);
      if (BVALID || RVALID) begin
        v_seen = c;
      end else begin
        if (PSEL !== (mapped ? (NS'(1) << idx) : NS'(0))) psel_ok = 1'b0;
        if (PENABLE !== (mapped && c >= 2)) pen_ok = 1'b0;
        if (mapped && (PADDR !== a[15:0] || PWRITE !== srv_wr || PWDATA !== (srv_wr ? wdata : 32'd0)))
          apb_ok = 1'b0;
`ifdef AXI2APB_APB4_EN
        if (mapped && (PSTRB !== (srv_wr ? wstrb : 4'd0) || PPROT !== (srv_wr ? awprot : arprot)))
          apb_ok = 1'b0;
`endif
      end
    end
    check_eq("valid_cycle", v_seen, v_exp);
    check_eq("psel", psel_ok, 1'b1);
    check_eq("penable", pen_ok, 1'b1);
    check_eq("apb_req", apb_ok, 1'b1);
    if (v_seen > 0) begin
      check_eq("valid_kind", {BVALID, RVALID}, {srv_wr, !srv_wr});
      check_eq("apb_released", {PSEL, PENABLE}, 64'd0);
      check_eq("resp", srv_wr ? BRESP : RRESP, resp_exp);
      if (!srv_wr) check_eq("rdata", RDATA, rdata_exp);
      // Response held while the master stalls; new requests are refused
      for (int k = 1; k <= resp_dly; k++) begin
        @(posedge ACLK); #1;
        BREADY  = (k == resp_dly); RREADY = (k == resp_dly);
        AWVALID = (k < resp_dly); WVALID = (k < resp_dly); ARVALID = (k < resp_dly);
        @(negedge ACLK);
        if ((srv_wr ? BVALID : RVALID) !== 1'b1) hold_ok = 1'b0;
        if ((srv_wr ? BRESP : RRESP) !== resp_exp) hold_ok = 1'b0;
        if (!srv_wr && RDATA !== rdata_exp) hold_ok = 1'b0;
        if (AWREADY || WREADY || ARREADY) hold_ok = 1'b0;
      end
      if (resp_dly > 0) check_eq("resp_hold", hold_ok, 1'b1);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return (32'($urandom_range(0, NS - 1)) << 16) | ($urandom & 32'h0000_FFFC);
    else if (r == 7) return (32'($urandom_range(NS, 7)) << 16) | ($urandom & 32'h0000_FFFC);
    else if (r == 8) return $urandom | 32'h0100_0000;
    else             return $urandom;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1;
    AWADDR = '0; AWVALID = 1'b0; AWPROT = '0; WDATA = '0; WVALID = 1'b0;
    ARADDR = '0; ARVALID = 1'b0; ARPROT = '0; BREADY = 1'b0; RREADY = 1'b0;
    PRDATA = '0; PREADY = '1; PSLVERR = '0;
`ifdef AXI2APB_APB4_EN
    WSTRB = '0;
`endif
    wr_turn = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_all_zero("reset");
    @(posedge ACLK); #1; ARESET = 1'b0;

    // Tie on three transactions: read, write (stalled response), read (unmapped)
    run_txn(1, 1, 32'h0002_0010, 32'h0001_0004, 32'hDEAD_BEEF, 3, 0, 32'h1234_5678, 0, 4'hF, 3'd0, 3'd0);
    run_txn(1, 1, 32'h0002_0010, 32'h0001_0004, 32'hDEAD_BEEF, 0, 0, 32'h0, 5, 4'hF, 3'd0, 3'd0);
    run_txn(1, 1, 32'h0002_0010, 32'h0004_0000, 32'hDEAD_BEEF, 0, 0, 32'h0, 0, 4'hF, 3'd0, 3'd0);
    // Timeout on slave 3, and PREADY arriving on the very last allowed cycle
    run_txn(1, 0, 32'h0003_0100, 32'h0, 32'hA5A5_0001, TOUT + 5, 0, 32'h0, 1, 4'hF, 3'd0, 3'd0);
    run_txn(0, 1, 32'h0, 32'h0000_0008, 32'h0, TOUT, 0, 32'hCAFE_0001, 0, 4'h0, 3'd0, 3'd5);
    run_txn(0, 1, 32'h0, 32'h0003_0008, 32'h0, TOUT + 1, 0, 32'hCAFE_0002, 0, 4'h0, 3'd0, 3'd0);
    // Slave error on read, unmapped write via a high address bit, strobed write
    run_txn(0, 1, 32'h0, 32'h0002_0040, 32'h0, 1, 1, 32'hFFFF_FFFF, 2, 4'h0, 3'd0, 3'd1);
    run_txn(1, 0, 32'h8000_0000, 32'h0, 32'h1111_2222, 0, 0, 32'h0, 0, 4'hF, 3'd0, 3'd0);
    run_txn(1, 0, 32'h0000_0020, 32'h0, 32'h0BAD_F00D, 2, 0, 32'h0, 0, 4'b0011, 3'b010, 3'd0);

    for (int t = 0; t < 40; t++) begin
      int kind, w;
      kind = $urandom_range(0, 2);
      w    = ($urandom_range(0, 9) == 0) ? TOUT + 4 : $urandom_range(0, 4);
      run_txn(kind != 1, kind != 0, rand_addr(), rand_addr(), $urandom, w,
              $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3),
              4'($urandom), 3'($urandom), 3'($urandom));
    end

    // Reset while a write sits in ACCESS waiting on a silent slave
    @(posedge ACLK); #1;
    AWVALID = 1'b1; WVALID = 1'b1; AWADDR = 32'h0001_0008; WDATA = 32'h5555_AAAA;
    AWPROT = 3'b010; BREADY = 1'b1; RREADY = 1'b1; PREADY = '0;
`ifdef AXI2APB_APB4_EN
    WSTRB = 4'b0011;
`endif
    @(negedge ACLK);
    check_eq("rst_hs", AWREADY, 1'b1);
    @(posedge ACLK); #1; AWVALID = 1'b0; WVALID = 1'b0;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    check_eq("rst_in_access", {PSEL, PENABLE}, {4'b0010, 1'b1});
`ifdef AXI2APB_APB4_EN
    check_eq("rst_apb4", {PSTRB, PPROT}, {4'b0011, 3'b010});
`endif
    @(posedge ACLK); #1; ARESET = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    check_all_zero("mid_reset");
    @(posedge ACLK); #1; ARESET = 1'b0; PREADY = '1; wr_turn = 1'b0;
    @(negedge ACLK);
    check_eq("no_resp_after_reset", {BVALID, RVALID}, 64'd0);
    // Pointer back to read after reset
    run_txn(1, 1, 32'h0000_0004, 32'h0001_000C, 32'h7777_8888, 0, 0, 32'h9999_AAAA, 0, 4'hF, 3'd0, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi2apb_bridge_mp.md
# axi2apb_bridge_mp

Parametrised AXI4-Lite slave to APB master bridge. It generalises the single-slave bridge to NUM_SLV APB slaves, each with its own PSEL line, and decodes the slave from the AXI address. It adds fair read/write arbitration, an APB access timeout and DECERR for unmapped addresses. It sits between the AXI-Lite interconnect and the peripheral APB segment, on a single clock domain.

## Interface
- ADDR_WIDTH, 32: AXI address width.
- DATA_WIDTH, 32: AXI/APB data width; must be 32 or 64.
- APB_ADDR_WIDTH, 16: PADDR width; also the size of each slave window.
- NUM_SLV, 4: APB slave count, 1..16; SLV_BITS = clog2(NUM_SLV), minimum 1.
- TOUT_CYCLES, 16: maximum ACCESS-phase cycles waiting for PREADY; 2..255.
- UD, 1: unit delay on registered outputs (simulation only).
- ACLK  in  1  clock for AXI and APB sides.
- ARESET  in  1  reset; synchronous, active-high.
- AWADDR/AWVALID/AWPROT  in  ADDR_WIDTH/1/3; AWREADY  out  1.
- WDATA/WVALID  in  DATA_WIDTH/1; WREADY  out  1.
- BRESP  out  2; BVALID  out  1; BREADY  in  1.
- ARADDR/ARVALID/ARPROT  in  ADDR_WIDTH/1/3; ARREADY  out  1.
- RDATA  out  DATA_WIDTH; RRESP  out  2; RVALID  out  1; RREADY  in  1.
- PADDR  out  APB_ADDR_WIDTH; PWRITE/PENABLE  out  1; PSEL  out  NUM_SLV (one-hot).
- PWDATA  out  DATA_WIDTH; PRDATA  in  NUM_SLV*DATA_WIDTH (slave i at [i*DATA_WIDTH +: DATA_WIDTH]).
- PREADY, PSLVERR  in  NUM_SLV  per-slave signals.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE, accepting a write: requires AWVALID&&WVALID. The bridge pulses AWREADY and WREADY together for one cycle and latches the address, data and PROT.
- IDLE, accepting a read: requires ARVALID. The bridge pulses ARREADY for one cycle and latches the address.
- Arbitration: if a write and a read are both eligible, the one not served last wins (round robin). After reset, read has priority.
- A lone AWVALID without WVALID, or the reverse, is not accepted and does not block reads.
- Decode: slave index = addr[APB_ADDR_WIDTH +: SLV_BITS]. Unmapped means index ≥ NUM_SLV, or any addr bit above APB_ADDR_WIDTH+SLV_BITS is set.
- Unmapped access: goes IDLE→RESP with no APB activity. Response is DECERR; RDATA = 0.
- Mapped access: IDLE→SETUP→ACCESS. PADDR = addr[APB_ADDR_WIDTH-1:0]. The selected PSEL bit is high in SETUP and ACCESS. PENABLE is high in ACCESS only. PWRITE and PWDATA are stable from SETUP to the end of ACCESS.
- ACCESS ends when PREADY[idx]=1. RRESP/BRESP = PSLVERR[idx] ? SLVERR : OKAY. RDATA captures PRDATA[idx] on reads; it is 0 on writes and errors.
- Timeout: if a counter reaches TOUT_CYCLES in ACCESS without PREADY, PSEL and PENABLE drop and the response is SLVERR, RDATA = 0. The counter clears on SETUP.
- RESP: BVALID or RVALID is held, with data and response stable, until BREADY or RREADY. The FSM then returns to IDLE.
- Only one outstanding transaction; all READY outputs are low outside IDLE.

## Timing
- Reset values: every output is 0, including AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA, PSEL, PENABLE, PWRITE, PADDR and PWDATA. FSM resets to IDLE and the arbitration pointer to read.
- Mapped access with zero-wait slave: handshake cycle 0, SETUP cycle 1, ACCESS cycle 2 (PREADY=1), VALID cycle 3. Back-to-back throughput is one transfer per 4 cycles plus READY latency.
- Each PREADY=0 cycle adds one cycle of latency.
- Unmapped access: handshake cycle 0, VALID cycle 1.
- Timeout: VALID occurs exactly TOUT_CYCLES+1 cycles after entering ACCESS.
- BREADY/RREADY already high when VALID rises: the handshake completes that cycle, IDLE follows on the next cycle, and a new AXI handshake can occur there.
- ARESET mid-transfer: all outputs return to 0 on the next edge. The transaction is abandoned and no response is issued.

## Configuration
- AXI2APB_APB4_EN defined: adds input WSTRB (DATA_WIDTH/8), output PSTRB (DATA_WIDTH/8) and output PPROT (3).
  - PSTRB carries the latched WSTRB; it is all-zero on reads.
  - PPROT carries the latched AWPROT or ARPROT.
  - Both reset to 0 and are stable from SETUP to the end of ACCESS.
- Not defined: these ports are absent. All writes are full-word and PROT is ignored.

## Test plan
- Write 0x0002_0010 = 0xDEAD_BEEF with NUM_SLV=4 and zero-wait slave: PSEL=4'b0100 in cycles 1-2, PADDR=0x0010, BVALID in cycle 3, BRESP=OKAY.
- Read 0x0001_0004 while slave 1 holds PREADY low 3 cycles and returns 0x1234_5678: RVALID in cycle 6, RDATA=0x1234_5678, RRESP=OKAY.
- Read 0x0004_0000 (unmapped): no PSEL bit ever high; RVALID in cycle 1, RRESP=DECERR, RDATA=0.
- Write to slave 3 with PREADY stuck low and TOUT_CYCLES=16: PSEL drops after 16 ACCESS cycles, BRESP=SLVERR.
- AW/W and AR asserted together on three consecutive transactions after reset: service order read, write, read. With BREADY low for 5 cycles, BVALID and BRESP stay held and no new READY is asserted.
- Under AXI2APB_APB4_EN, write with WSTRB=4'b0011 and AWPROT=3'b010: PSTRB=0011 and PPROT=010 during SETUP and ACCESS. Assert ARESET in ACCESS: all outputs are 0 next cycle.
